// File: rtl/turbo_itl_pkg.sv
// turbo_itl_pkg: shared FSM states, read latency and modular-add helper for turbo_itl_rx_par
package turbo_itl_pkg;
  typedef enum logic [1:0] {IDLE, INIT, READ, DRAIN} state_t;
  localparam int RD_LAT = 2;
  function automatic logic [31:0] mod_add(input logic [31:0] a, input logic [31:0] b, input logic [31:0] l);
    return (a + b >= l) ? a + b - l : a + b;
  endfunction
endpackage

// File: rtl/turbo_itl_rx_par_bank.sv
// itl_bank: 1W1R synchronous RAM with registered read; read-during-write returns old data
module itl_bank #(
  parameter int SW = 2,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [SW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [SW-1:0] rdata
);
  logic [SW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/turbo_itl_rx_par.sv
// turbo_itl_rx_par: PB interleaver buffer with NLANE-wide permuted/linear read-out
// Optional macro TURBO_ITL_PINGPONG_EN selects a two-bank ping-pong buffer.
module turbo_itl_rx_par
  import turbo_itl_pkg::*;
#(
  parameter int SW    = 2,
  parameter int NLANE = 4,
  parameter int AW    = 12
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                wen,
  input  logic [AW-1:0]       waddr,
  input  logic [SW-1:0]       wdata,
  input  logic                start,
  input  logic [AW-1:0]       pb_len,
  input  logic [AW-1:0]       pb_offset,
  input  logic [AW-1:0]       stride,
  input  logic                mod_int_dint,
  input  logic                din_vld,
  output logic [NLANE*SW-1:0] rdata,
  output logic                dout_vld,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam int LG = $clog2(NLANE);
  state_t state;
  logic [AW-1:0] len, step, stride_r, acc, beat, nb_m1;
  logic [AW-1:0] a [NLANE];
  logic [SW-1:0] q [NLANE];
  logic [NLANE*SW-1:0] nxt;
  logic [3:0] ic;
  logic [1:0] dc;
  logic mode, v1, l1, p1, m1, bad;
  assign bad = pb_len == '0 || (pb_len & AW'(NLANE - 1)) != '0 ||
               (mod_int_dint && (stride >= pb_len || pb_offset >= pb_len));
  assign nb_m1 = (len >> LG) - 1'b1;
  assign busy = state != IDLE;
  function automatic logic [AW-1:0] madd(input logic [AW-1:0] x, input logic [AW-1:0] y);
    return AW'(mod_add(32'(x), 32'(y), 32'(len)));
  endfunction
`ifdef TURBO_ITL_PINGPONG_EN
  localparam int NB = 2;
  logic wsel, rsel;
  always_ff @(posedge clk)
    if (n_rst) {wsel, rsel} <= '0;
    else if (state == IDLE && start && !bad) {wsel, rsel} <= {~wsel, wsel};
`else
  localparam int NB = 1;
  logic wsel, rsel;
  assign wsel = 1'b0;
  assign rsel = 1'b0;
`endif
  logic [SW-1:0] bank_q [NB][NLANE];
  for (genvar b = 0; b < NB; b++) begin : g_bank
    for (genvar k = 0; k < NLANE; k++) begin : g_lane
      itl_bank #(.SW(SW), .AW(AW)) u_bank (
        .clk,
        .wen(wen && wsel == 1'(b)),
        .waddr,
        .wdata,
        .raddr(a[k]),
        .rdata(bank_q[b][k])
      );
    end
  end
  for (genvar k = 0; k < NLANE; k++) begin : g_q
    assign q[k] = bank_q[rsel][k];
  end
  // Stream index i = c*NLANE+k; for NLANE>1 its parity is the lane parity.
  always_comb begin
    nxt = '0;
    for (int k = 0; k < NLANE; k++)
      for (int b = 0; b < SW; b++)
        nxt[k*SW+b] = (m1 && (NLANE == 1 ? p1 : k[0])) ? q[k][SW-1-b] : q[k][b];
  end
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state    <= IDLE;
      err      <= 1'b0;
      v1       <= 1'b0;
      l1       <= 1'b0;
      dout_vld <= 1'b0;
      done     <= 1'b0;
      rdata    <= '0;
    end else begin
      err      <= 1'b0;
      v1       <= 1'b0;
      l1       <= 1'b0;
      dout_vld <= v1;
      done     <= v1 && l1;
      if (v1) rdata <= nxt;
      case (state)
        IDLE: if (start) begin
          if (bad) err <= 1'b1;
          else begin
            state    <= INIT;
            len      <= pb_len;
            mode     <= mod_int_dint;
            stride_r <= mod_int_dint ? stride : AW'(1);
            acc      <= mod_int_dint ? pb_offset : '0;
            step     <= '0;
            ic       <= '0;
          end
        end
        INIT: begin
          for (int k = 0; k < NLANE; k++) if (ic == 4'(k)) a[k] <= acc;
          acc  <= madd(acc, stride_r);
          step <= madd(step, stride_r);
          ic   <= ic + 1'b1;
          beat <= '0;
          if (ic == 4'(NLANE - 1)) state <= READ;
        end
        READ: if (din_vld) begin
          v1 <= 1'b1;
          l1 <= beat == nb_m1;
          p1 <= beat[0];
          m1 <= mode;
          for (int k = 0; k < NLANE; k++) a[k] <= madd(a[k], step);
          beat <= beat + 1'b1;
          dc   <= '0;
          if (beat == nb_m1) state <= DRAIN;
        end
        DRAIN: begin
          dc <= dc + 1'b1;
          if (dc == 2'(RD_LAT - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_turbo_itl_rx_par.sv
// tb_turbo_itl_rx_par: scoreboard bench for turbo_itl_rx_par (optionally with TURBO_ITL_PINGPONG_EN)
module tb_turbo_itl_rx_par;
  localparam int SW = 2, NLANE = 4, AW = 12, P = 10;
  logic clk = 0, n_rst = 1, wen = 0, start = 0, mod_int_dint = 0, din_vld = 1;
  logic [AW-1:0] waddr = '0, pb_len = '0, pb_offset = '0, stride = '0;
  logic [SW-1:0] wdata = '0;
  logic [NLANE*SW-1:0] rdata;
  logic dout_vld, busy, done, err;
  typedef struct {logic [NLANE*SW-1:0] d; logic last;} exp_t;
  exp_t sb[$];
  logic [SW-1:0] mm [2**AW];
  int checks = 0, failures = 0;
  bit mon_en = 1, alt = 0, lat_pending = 0, prev_vld = 0, prev_done = 0;
  time t0;
  always #5 clk = ~clk;
  turbo_itl_rx_par #(.SW(SW), .NLANE(NLANE), .AW(AW)) dut (
    .clk, .n_rst, .wen, .waddr, .wdata, .start, .pb_len, .pb_offset, .stride,
    .mod_int_dint, .din_vld, .rdata, .dout_vld, .busy, .done, .err
  );
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask
  function automatic logic [1:0] pat(input int kind, input int i);
    int v;
    v = kind == 0 ? i : kind == 1 ? (i ^ (i >> 3)) : ~i;
    return v[1:0];
  endfunction
  task automatic wr(input int adr, input logic [SW-1:0] d);
    waddr = AW'(adr);
    wdata = d;
    wen = 1;
    mm[adr] = d;
    @(negedge clk);
    wen = 0;
  endtask
  task automatic fill(input int l, input int kind);
    for (int i = 0; i < l; i++) wr(i, pat(kind, i));
  endtask
  task automatic go(input int l, input int off, input int st, input bit mode, input bit push, input bit lat);
    exp_t e;
    int adr;
    logic [SW-1:0] v;
    pb_len = AW'(l);
    pb_offset = AW'(off);
    stride = AW'(st);
    mod_int_dint = mode;
    start = 1;
    t0 = $time;
    if (push)
      for (int c = 0; c < l / NLANE; c++) begin
        e.d = '0;
        for (int k = 0; k < NLANE; k++) begin
          adr = mode ? (off + (c * NLANE + k) * st) % l : c * NLANE + k;
          v = mm[adr];
          if (mode && (c * NLANE + k) % 2 == 1) v = {v[0], v[1]};
          e.d[k*SW+:SW] = v;
        end
        e.last = c == l / NLANE - 1;
        sb.push_back(e);
      end
    lat_pending = lat;
    @(negedge clk);
    start = 0;
  endtask
  task automatic run(input bit tog);
    int n;
    n = 0;
    while (n < 3000 && (busy || sb.size() != 0)) begin
      @(negedge clk);
      if (tog) din_vld = ~din_vld;
      n++;
    end
    if (n >= 3000) begin
      checks++;
      failures++;
      $display("FAIL timeout busy=%b pending=%0d want idle", busy, sb.size());
    end
    din_vld = 1;
    alt = 0;
    chk("sb_empty", 32'(sb.size()), 0);
  endtask
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (mon_en && dout_vld) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_dout rdata=%h want none", rdata);
      end else begin
        e = sb.pop_front();
        chk("rdata", 32'(rdata), 32'(e.d));
        chk("done", 32'(done), 32'(e.last));
        if (done) chk("busy_at_done", 32'(busy), 1);
      end
      if (lat_pending) chk("latency", 32'($time - t0), (NLANE + 3) * P);
      lat_pending = 0;
      if (alt) chk("stall_gap", 32'(prev_vld), 0);
    end
    if (mon_en && prev_done) chk("busy_fall", 32'(busy), 0);
    prev_vld = dout_vld;
    prev_done = done;
  end
  initial begin
    #500000;
    $display("FAIL watchdog time=%0t want finish", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_vld", 32'(dout_vld), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    n_rst = 0;
    @(negedge clk);
    fill(64, 0);
    go(64, 0, 0, 0, 1, 1);
    run(0);
    fill(64, 0);
    go(64, 0, 5, 1, 1, 1);
    run(0);
    fill(544, 1);
    alt = 1;
    go(544, 3, 7, 1, 1, 0);
    run(1);
    go(32'h42, 0, 0, 0, 0, 0);
    chk("err_len", 32'(err), 1);
    chk("err_len_busy", 32'(busy), 0);
    @(negedge clk);
    chk("err_pulse", 32'(err), 0);
    go(64, 0, 64, 1, 0, 0);
    chk("err_stride", 32'(err), 1);
    chk("err_stride_busy", 32'(busy), 0);
    @(negedge clk);
    chk("err_stride_idle", 32'(busy), 0);
    fill(64, 0);
    mon_en = 0;
    go(64, 0, 0, 0, 0, 0);
    repeat (9) @(negedge clk);
    n_rst = 1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_vld", 32'(dout_vld), 0);
    n_rst = 0;
    mon_en = 1;
    sb.delete();
    fill(64, 1);
    go(64, 0, 0, 0, 1, 1);
    run(0);
`ifdef TURBO_ITL_PINGPONG_EN
    fill(64, 0);
    go(64, 0, 0, 0, 1, 1);
    fill(64, 2);
    run(0);
    go(64, 0, 0, 0, 1, 1);
    run(0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/turbo_itl_rx_par.md
Name: turbo_itl_rx_par

Overview:
- Parametrised successor to the turbo_rx interleaver buffer used in the HPGP turbo receive path.
- Per physical block (PB), the block accepts soft-pair writes at explicit addresses into an internal buffer.
- On start, it streams the PB back out on NLANE parallel lanes in either permuted (interleave) or linear order.
- It sits between the demapper/deframer write side and the NLANE-wide turbo decoder input.
- Generalised over soft width, lane count and address width; adds a programmable stride/offset permutation, error flagging and busy/done status.

Parameters:
- SW, 2, soft-value width per entry (bits).
- NLANE, 4, parallel output lanes; power of two, 1..8.
- AW, 12, address width; buffer depth 2**AW entries.

Ports:
- clk  in  1  clock.
- n_rst  in  1  reset; one clock; reset is synchronous and active-high (asserted level 1; port name kept per codebase convention).
- wen  in  1  write strobe.
- waddr  in  AW  write address.
- wdata  in  SW  write data.
- start  in  1  one-cycle pulse launching a read-out; sampled in IDLE only.
- pb_len  in  AW  PB length in entries; sampled on start.
- pb_offset  in  AW  permutation start offset; sampled on start.
- stride  in  AW  permutation stride; sampled on start.
- mod_int_dint  in  1  1 = interleave (permuted read), 0 = deinterleave/linear read (stride=1, offset=0 forced); sampled on start.
- din_vld  in  1  read-enable qualifier; READ advances only while 1.
- rdata  out  NLANE*SW  lane k occupies bits [k*SW +: SW].
- dout_vld  out  1  rdata valid.
- busy  out  1  FSM not IDLE.
- done  out  1  one-cycle pulse with the last valid dout.
- err  out  1  one-cycle pulse on rejected start.

Behaviour:
- Reset: FSM=IDLE; rdata=0, dout_vld=0, busy=0, done=0, err=0; buffer contents undefined (not cleared).
- Writes: mem[waddr] <= wdata when wen=1, in any state; writes ignore din_vld.
- A same-cycle write and read of one address returns the old data.
- start checks (IDLE only): reject if pb_len==0, pb_len % NLANE != 0, or (mod_int_dint && (stride>=pb_len || pb_offset>=pb_len)).
  - Reject: err=1 for one cycle; remain IDLE.
- start while busy: ignored; no err.
- FSM: IDLE -> INIT -> READ -> DRAIN -> IDLE.
- INIT, exactly NLANE cycles, all arithmetic by conditional-subtract modular add (no multiplier):
  - a0 = offset.
  - a_k = (a_{k-1} + stride) mod L.
  - step_n = (NLANE*stride) mod L, via NLANE successive modular adds.
- READ, L/NLANE beats:
  - On each beat with din_vld=1, lane k reads mem[a_k].
  - Then a_k <= a_k + step_n, minus L if the result is >= L.
  - Beat counter is AW bits wide.
  - din_vld=0 stalls the beat with no address advance.
- Read latency: 2 cycles (registered RAM read plus output register).
  - dout_vld follows the issuing beat by exactly 2 cycles.
  - Stalls propagate as dout_vld=0 gaps.
- Interleave-mode pair swap: output entry bits reversed ({b0,b1}) when index i=c*NLANE+k is odd. Linear mode never swaps.
- DRAIN: 2 cycles. done pulses coincident with the final dout_vld; busy falls the cycle after.
- n_rst mid-operation: immediate IDLE next edge; in-flight dout_vld squashed.

Optional Feature:
- Macro TURBO_ITL_PINGPONG_EN.
- Defined:
  - Two buffer banks.
  - Writes go to bank wsel; start swaps wsel and reads the bank just written.
  - The next PB may be written during READ.
- Undefined:
  - Single bank.
  - Writes during busy still land; the user must not overwrite unread entries.

Decomposition:
- Package turbo_itl_pkg holds:
  - the FSM state enum;
  - latency constant RD_LAT=2;
  - function mod_add(a,b,L), returning a+b-L if a+b>=L, else a+b.
- Sub-module itl_bank: 1W1R synchronous RAM (2**AW x SW), instantiated NLANE times (x2 with ping-pong) to give parallel read ports.

Test Plan:
- Linear, L=0x40: write mem[i]=i[1:0]; start with mod_int_dint=0; din_vld held 1.
  -> 16 beats; beat c lanes = {3,2,1,0} per entry; dout_vld 2 cycles after the first READ beat; done on beat 16.
- Interleave, L=64, offset=0, stride=5, mem[i]=i[1:0]:
  -> beat0 addresses 0,5,10,15; beat3 lane1 address 65 mod 64=1.
  -> odd-index entries bit-swapped.
- L=0x220, stride=7, offset=3, din_vld toggling 1/0:
  -> 136 valid beats, order unchanged, each gap reflected in dout_vld.
- start with pb_len=0x42 (not multiple of 4), then stride=0x40 with L=0x40:
  -> err pulse each time, busy stays 0.
- Reset asserted mid-READ (beat 5):
  -> next cycle busy=0 and dout_vld=0; a new start completes normally.
- With TURBO_ITL_PINGPONG_EN: write PB B during readout of PB A.
  -> A data unaffected; second start reads B.
